img_cmd_frontend: RTL and testbench
===================================

Name: img_cmd_frontend

Overview:
- Host-side command parser that sits directly upstream of img_conv_top.
- Consumes a byte stream from the host link (UART rx FIFO) and drives the top's op/en/din.
- Streams image bytes in and out, waits on the top's busy, and returns response/ack bytes on the host tx link.
- Sole owner of the top's control inputs.

Parameters:
- ACK_BYTE, 8'hA5, sent on completion of SET/IMG_RX/CONV.
- ERR_BYTE, 8'hEE, sent on an invalid opcode.
- TIMEOUT_CYC, 1_000_000, idle-arg timeout, used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rx_data  in  8  host byte
- rx_valid  in  1  host byte valid
- rx_ready  out  1  frontend accepts rx_data this cycle
- tx_data  out  8  response byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host link accepts tx_data
- core_op  out  4  opcode to img_conv_top
- core_en  out  1  one-cycle start strobe
- core_din  out  8  argument / image byte
- core_din_valid  out  1  image byte strobe during IMG_RX stream
- core_dout  in  8  byte from img_conv_top
- core_dout_valid  in  1  image byte strobe during IMG_TX stream
- core_dout_ready  out  1  backpressure to core during IMG_TX
- core_busy  in  1  top busy

Behaviour:
- Opcodes (4-bit, low nibble of command byte; upper nibble ignored): NOP=0, GET_NROWS=1, GET_NCOLS=2, GET_SIGMA=3, SET_NROWS=4, SET_NCOLS=5, SET_SIGMA=6, IMG_RX=7, IMG_TX=8, CONV=9. Values 10-15 are invalid.
- Reset values: all outputs 0, state IDLE, shadow nrows=8, ncols=8, byte counter 0.
- rx handshake: byte consumed on rx_valid&&rx_ready. rx_ready=1 only in IDLE, ARG, STREAM_RX.
- tx handshake: tx_data must stay stable while tx_valid&&!tx_ready. tx_valid drops the cycle after acceptance.
- States:
  - IDLE: accept a command byte. NOP -> stay, no response. Invalid -> RESP with ERR_BYTE. SET_* -> ARG. Other valid opcodes -> ISSUE.
  - ARG: accept one byte into core_din. SET_NROWS/SET_NCOLS also update the shadow register (0 is stored as-is). -> ISSUE.
  - ISSUE: core_op valid and core_en=1 for exactly one cycle. GET_* -> GETCAP. SET_* -> SETWAIT. IMG_RX -> STREAM_RX. IMG_TX -> STREAM_TX. CONV -> BUSYWAIT.
  - GETCAP: one cycle, because the top registers core_dout one cycle after en. Capture core_dout -> RESP with the captured byte.
  - SETWAIT: one cycle -> RESP with ACK_BYTE.
  - STREAM_RX: each accepted rx byte is driven on core_din with a one-cycle core_din_valid pulse the next cycle. Byte count = nrows*ncols (16-bit, 8x8 product). A 0 count goes straight to BUSYWAIT. After the last byte -> BUSYWAIT.
  - STREAM_TX: core_dout_ready = !tx_valid || tx_ready. Each core_dout_valid byte is loaded into tx_data. core_dout_valid while core_dout_ready=0 is a protocol error and the byte is dropped. After nrows*ncols bytes -> BUSYWAIT; on busy low -> IDLE with no ack.
  - BUSYWAIT: ignore core_busy in the first cycle (top's busy lands one cycle after en). Then wait for core_busy=0 -> RESP with ACK_BYTE.
  - RESP: hold tx_valid until accepted -> IDLE.
- core_en is never asserted while core_busy=1 or outside ISSUE.
- rx bytes arriving while rx_ready=0 are left in the upstream FIFO, not dropped.
- Asynchronous reset mid-stream: immediate return to IDLE and all outputs to 0. The top is reset by the same rstn.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - Counter runs in ARG and STREAM_RX while rx_valid=0, cleared on each accepted byte.
  - Reaching TIMEOUT_CYC -> RESP with ERR_BYTE, then IDLE.
  - In STREAM_RX, a timeout still waits for core_busy low before RESP, so the top completes.
- Undefined: no counter; ARG/STREAM_RX wait indefinitely.

Test Plan:
- Reset then send 0x01 -> core_en pulse with core_op=1; tx byte 0x08 (default nrows).
- Send 0x04, 0x05 then 0x01 -> core_din=0x05 with op=4 on core_en; ACK 0xA5; subsequent GET returns 0x05.
- Send 0x0C -> tx 0xEE; core_en never asserts.
- SET_NROWS 2, SET_NCOLS 3, then 0x07 followed by 6 bytes 0x10..0x15 -> six core_din_valid pulses with those values; hold core_busy 4 cycles; ACK 0xA5 only after busy low.
- 2x3 image, 0x08 with tx_ready toggling 50% -> 6 core_dout bytes emitted in order, tx_data stable under stall, core_dout_ready deasserted while stalled.
- With CMD_TIMEOUT_EN and TIMEOUT_CYC=100: send 0x06 then idle 100 cycles -> tx 0xEE, return to IDLE, next 0x03 handled normally.

Source files
------------

// File: rtl/img_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module : img_cmd_frontend
// Host byte-command parser; sole driver of img_conv_top control inputs.
// Optional: CMD_TIMEOUT_EN adds an idle-argument timeout of TIMEOUT_CYC cycles.
// Rev    : 1.0
// ============================================================================
module img_cmd_frontend #(
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [3:0] core_op_o,
    output logic       core_en_o,
    output logic [7:0] core_din_o,
    output logic       core_din_valid_o,
    input  logic [7:0] core_dout_i,
    input  logic       core_dout_valid_i,
    output logic       core_dout_ready_o,
    input  logic       core_busy_i
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ARG       = 4'd1;
    localparam logic [3:0] S_ISSUE     = 4'd2;
    localparam logic [3:0] S_GETCAP    = 4'd3;
    localparam logic [3:0] S_SETWAIT   = 4'd4;
    localparam logic [3:0] S_STREAM_RX = 4'd5;
    localparam logic [3:0] S_STREAM_TX = 4'd6;
    localparam logic [3:0] S_BUSYWAIT  = 4'd7;
    localparam logic [3:0] S_RESP      = 4'd8;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_GET_SIGMA = 4'd3;
    localparam logic [3:0] OP_SET_NROWS = 4'd4;
    localparam logic [3:0] OP_SET_NCOLS = 4'd5;
    localparam logic [3:0] OP_SET_SIGMA = 4'd6;
    localparam logic [3:0] OP_IMG_RX    = 4'd7;
    localparam logic [3:0] OP_IMG_TX    = 4'd8;
    localparam logic [3:0] OP_CONV      = 4'd9;

    logic [3:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  nrows_q, nrows_d;
    logic [7:0]  ncols_q, ncols_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  din_q, din_d;
    logic        din_valid_q, din_valid_d;
    logic        rx_ready_q, rx_ready_d;
    logic        bw_first_q, bw_first_d;
    logic        err_q, err_d;

    logic [3:0]  w_op;
    logic        w_rx_acc;
    logic        w_dout_rdy;
    logic [15:0] w_total;
    logic [15:0] w_cnt_inc;
    logic        w_to_fire;

    assign w_op       = rx_data_i[3:0];
    assign w_rx_acc   = rx_valid_i && rx_ready_q;
    assign w_dout_rdy = (state_q == S_STREAM_TX) && (!tx_valid_q || tx_ready_i);
    assign w_total    = {8'd0, nrows_q} * {8'd0, ncols_q};
    assign w_cnt_inc  = cnt_q + 16'd1;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counts consecutive idle cycles while an argument or image byte is owed.
    always_comb begin
        to_cnt_d  = '0;
        w_to_fire = 1'b0;
        if (((state_q == S_ARG) || (state_q == S_STREAM_RX)) && !rx_valid_i) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                w_to_fire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        nrows_d     = nrows_q;
        ncols_d     = ncols_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        din_d       = din_q;
        din_valid_d = 1'b0;
        bw_first_d  = bw_first_q;
        err_d       = err_q;

        if (tx_valid_q && tx_ready_i) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_rx_acc && (w_op != OP_NOP)) begin
                    if (w_op > OP_CONV) begin
                        tx_data_d  = ERR_BYTE;
                        tx_valid_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        op_d    = w_op;
                        state_d = ((w_op >= OP_SET_NROWS) && (w_op <= OP_SET_SIGMA)) ? S_ARG : S_ISSUE;
                    end
                end
            end
            S_ARG: begin
                if (w_rx_acc) begin
                    din_d = rx_data_i;
                    if (op_q == OP_SET_NROWS) nrows_d = rx_data_i;
                    if (op_q == OP_SET_NCOLS) ncols_d = rx_data_i;
                    state_d = S_ISSUE;
                end else if (w_to_fire) begin
                    tx_data_d  = ERR_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_ISSUE: begin
                // Holding here while busy keeps core_en off until the top is free.
                if (!core_busy_i) begin
                    cnt_d      = '0;
                    bw_first_d = 1'b1;
                    case (op_q)
                        OP_IMG_RX: state_d = (w_total == 16'd0) ? S_BUSYWAIT : S_STREAM_RX;
                        OP_IMG_TX: state_d = (w_total == 16'd0) ? S_BUSYWAIT : S_STREAM_TX;
                        OP_CONV:   state_d = S_BUSYWAIT;
                        default:   state_d = (op_q <= OP_GET_SIGMA) ? S_GETCAP : S_SETWAIT;
                    endcase
                end
            end
            S_GETCAP: begin
                tx_data_d  = core_dout_i;
                tx_valid_d = 1'b1;
                state_d    = S_RESP;
            end
            S_SETWAIT: begin
                tx_data_d  = ACK_BYTE;
                tx_valid_d = 1'b1;
                state_d    = S_RESP;
            end
            S_STREAM_RX: begin
                if (w_rx_acc) begin
                    din_d       = rx_data_i;
                    din_valid_d = 1'b1;
                    cnt_d       = w_cnt_inc;
                    if (w_cnt_inc == w_total) begin
                        state_d    = S_BUSYWAIT;
                        bw_first_d = 1'b1;
                    end
                end else if (w_to_fire) begin
                    err_d      = 1'b1;
                    state_d    = S_BUSYWAIT;
                    bw_first_d = 1'b1;
                end
            end
            S_STREAM_TX: begin
                if (core_dout_valid_i && w_dout_rdy) begin
                    tx_data_d  = core_dout_i;
                    tx_valid_d = 1'b1;
                    cnt_d      = w_cnt_inc;
                    if (w_cnt_inc == w_total) begin
                        state_d    = S_BUSYWAIT;
                        bw_first_d = 1'b1;
                    end
                end
            end
            S_BUSYWAIT: begin
                // Busy from the top lags core_en by a cycle, so the first cycle is skipped.
                if (bw_first_q) begin
                    bw_first_d = 1'b0;
                end else if (!core_busy_i && !tx_valid_q) begin
                    if (err_q) begin
                        err_d      = 1'b0;
                        tx_data_d  = ERR_BYTE;
                        tx_valid_d = 1'b1;
                        state_d    = S_RESP;
                    end else if (op_q == OP_IMG_TX) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_data_d  = ACK_BYTE;
                        tx_valid_d = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (tx_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ARG) || (state_d == S_STREAM_RX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            nrows_q     <= 8'd8;
            ncols_q     <= 8'd8;
            cnt_q       <= 16'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            din_q       <= 8'd0;
            din_valid_q <= 1'b0;
            rx_ready_q  <= 1'b0;
            bw_first_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            nrows_q     <= nrows_d;
            ncols_q     <= ncols_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            din_q       <= din_d;
            din_valid_q <= din_valid_d;
            rx_ready_q  <= rx_ready_d;
            bw_first_q  <= bw_first_d;
            err_q       <= err_d;
        end
    end

    assign rx_ready_o        = rx_ready_q;
    assign tx_data_o         = tx_data_q;
    assign tx_valid_o        = tx_valid_q;
    assign core_op_o         = op_q;
    assign core_en_o         = (state_q == S_ISSUE) && !core_busy_i;
    assign core_din_o        = din_q;
    assign core_din_valid_o  = din_valid_q;
    assign core_dout_ready_o = w_dout_rdy;

endmodule

`default_nettype wire

// File: tb/tb_img_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_img_cmd_frontend
// Directed self-checking bench for img_cmd_frontend with a tiny img_conv_top stand-in.
// Rev    : 1.0
// ============================================================================
module tb_img_cmd_frontend;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [3:0] core_op;
    logic       core_en;
    logic [7:0] core_din;
    logic       core_din_valid;
    logic [7:0] core_dout = 8'h5A;
    logic       core_dout_valid = 1'b0;
    logic       core_dout_ready;
    logic       core_busy = 1'b0;

    always #5 clk = ~clk;

`ifdef CMD_TIMEOUT_EN
    img_cmd_frontend #(.TIMEOUT_CYC(100)) dut (
`else
    img_cmd_frontend dut (
`endif
        .clk(clk), .rstn(rstn),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .core_op_o(core_op), .core_en_o(core_en), .core_din_o(core_din),
        .core_din_valid_o(core_din_valid), .core_dout_i(core_dout),
        .core_dout_valid_i(core_dout_valid), .core_dout_ready_o(core_dout_ready),
        .core_busy_i(core_busy)
    );

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    int en_busy_viol = 0;
    int stall_viol = 0;
    int drdy_viol = 0;
    logic [7:0] tx_log[$];
    logic [7:0] din_log[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         tx_toggle = 1'b0;

    // Stand-in for img_conv_top register file (reset by the same rstn).
    logic [7:0] m_nrows = 8'd8;
    logic [7:0] m_ncols = 8'd8;
    logic [7:0] m_sigma = 8'h33;
    logic [3:0] seen_op;
    logic [7:0] seen_din;

    always @(negedge clk) begin
        if (core_en) begin
            en_cnt++;
            if (core_busy) en_busy_viol++;
        end
        if (core_din_valid) din_log.push_back(core_din);
        if (prev_stall && (!tx_valid || (tx_data !== prev_data))) stall_viol++;
        if (tx_valid && !tx_ready && core_dout_ready) drdy_viol++;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    always @(posedge clk) begin
        #1 tx_ready = tx_toggle ? ~tx_ready : 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            tests++; fails++;
            $display("FAIL send_byte_%02h: rx_ready=%b, required 1", b, rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_en(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_en && n < budget);
        if (!core_en) begin
            tests++; fails++;
            $display("FAIL wait_en: core_en=%b after %0d cycles, required 1", core_en, n);
            return;
        end
        seen_op  = core_op;
        seen_din = core_din;
        case (core_op)
            4'd4: m_nrows = core_din;
            4'd5: m_ncols = core_din;
            4'd6: m_sigma = core_din;
            default: ;
        endcase
        if (core_op >= 4'd1 && core_op <= 4'd3) begin
            @(posedge clk);
            #1 core_dout = (core_op == 4'd1) ? m_nrows : (core_op == 4'd2) ? m_ncols : m_sigma;
            @(posedge clk);
            #1 core_dout = 8'h5A;
        end
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (tx_log.size() < n) begin
            tests++; fails++;
            $display("FAIL wait_tx: %0d tx bytes seen, required %0d", tx_log.size(), n);
            while (tx_log.size() < n) tx_log.push_back(8'hXX);
        end
    endtask

    task automatic set_param(input logic [7:0] cmd, input logic [7:0] val);
        int base;
        base = tx_log.size();
        send_byte(cmd);
        send_byte(val);
        wait_en(10);
        wait_tx(base + 1, 20);
        tests++;
        if (seen_op !== cmd[3:0] || seen_din !== val || tx_log[base] !== 8'hA5) begin
            fails++;
            $display("FAIL set_%02h: op=%h din=%h tx=%h, required op=%h din=%h tx=a5",
                     cmd, seen_op, seen_din, tx_log[base], cmd[3:0], val);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({rx_ready, tx_valid, tx_data, core_op, core_en, core_din, core_din_valid, core_dout_ready} !== 30'd0) begin
            fails++;
            $display("FAIL reset_outputs: rx_ready=%b tx_valid=%b tx_data=%h op=%h en=%b din=%h dv=%b drdy=%b, required all 0",
                     rx_ready, tx_valid, tx_data, core_op, core_en, core_din, core_din_valid, core_dout_ready);
        end
        rstn = 1'b1;
        @(negedge clk);
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rx_ready: rx_ready=%b, required 1", rx_ready);
        end
    endtask

    task automatic test_get_default;
        int base;
        base = tx_log.size();
        send_byte(8'h01);
        wait_en(10);
        wait_tx(base + 1, 20);
        tests++;
        if (seen_op !== 4'd1 || tx_log[base] !== 8'h08) begin
            fails++;
            $display("FAIL get_default: op=%h tx=%h, required op=1 tx=08", seen_op, tx_log[base]);
        end
    endtask

    task automatic test_set_get;
        int base;
        set_param(8'h04, 8'h05);
        base = tx_log.size();
        send_byte(8'h01);
        wait_en(10);
        wait_tx(base + 1, 20);
        tests++;
        if (tx_log[base] !== 8'h05) begin
            fails++;
            $display("FAIL get_after_set: tx=%h, required 05", tx_log[base]);
        end
        // Upper nibble of the command byte is ignored: F2 behaves as GET_NCOLS.
        send_byte(8'hF2);
        wait_en(10);
        wait_tx(base + 2, 20);
        tests++;
        if (seen_op !== 4'd2 || tx_log[base+1] !== 8'h08) begin
            fails++;
            $display("FAIL upper_nibble: op=%h tx=%h, required op=2 tx=08", seen_op, tx_log[base+1]);
        end
    endtask

    task automatic test_invalid;
        int base;
        int c;
        base = tx_log.size();
        c    = en_cnt;
        send_byte(8'h0C);
        wait_tx(base + 1, 20);
        send_byte(8'h00);
        send_byte(8'hFF);
        wait_tx(base + 2, 20);
        repeat (5) @(negedge clk);
        tests++;
        if (tx_log[base] !== 8'hEE || tx_log[base+1] !== 8'hEE || tx_log.size() != base + 2 || en_cnt != c) begin
            fails++;
            $display("FAIL invalid_nop: tx0=%h tx1=%h ntx=%0d en_pulses=%0d, required ee ee ntx=%0d en_pulses=%0d",
                     tx_log[base], tx_log[base+1], tx_log.size(), en_cnt, base + 2, c);
        end
    endtask

    task automatic test_img_rx;
        int base;
        set_param(8'h04, 8'h02);
        set_param(8'h05, 8'h03);
        din_log.delete();
        base = tx_log.size();
        send_byte(8'h07);
        wait_en(10);
        tests++;
        if (seen_op !== 4'd7) begin
            fails++;
            $display("FAIL img_rx_op: op=%h, required 7", seen_op);
        end
        @(posedge clk);
        #1 core_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        repeat (2) @(negedge clk);
        tests++;
        if (din_log.size() != 6) begin
            fails++;
            $display("FAIL img_rx_count: din pulses=%0d, required 6", din_log.size());
        end
        for (int i = 0; i < 6 && i < din_log.size(); i++) begin
            tests++;
            if (din_log[i] !== 8'h10 + 8'(i)) begin
                fails++;
                $display("FAIL img_rx_byte%0d: din=%h, required %h", i, din_log[i], 8'h10 + 8'(i));
            end
        end
        repeat (4) @(negedge clk);
        tests++;
        if (tx_log.size() != base) begin
            fails++;
            $display("FAIL img_rx_early_ack: ntx=%0d while busy, required %0d", tx_log.size(), base);
        end
        core_busy = 1'b0;
        wait_tx(base + 1, 20);
        tests++;
        if (tx_log[base] !== 8'hA5) begin
            fails++;
            $display("FAIL img_rx_ack: tx=%h, required a5", tx_log[base]);
        end
    endtask

    task automatic test_zero_count;
        int base;
        set_param(8'h04, 8'h00);
        din_log.delete();
        base = tx_log.size();
        send_byte(8'h07);
        wait_en(10);
        @(posedge clk);
        #1 core_busy = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (tx_log.size() != base || din_log.size() != 0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_count_wait: ntx=%0d din=%0d rx_ready=%b, required ntx=%0d din=0 rx_ready=0",
                     tx_log.size(), din_log.size(), rx_ready, base);
        end
        core_busy = 1'b0;
        wait_tx(base + 1, 20);
        tests++;
        if (tx_log[base] !== 8'hA5) begin
            fails++;
            $display("FAIL zero_count_ack: tx=%h, required a5", tx_log[base]);
        end
        set_param(8'h04, 8'h02);
    endtask

    task automatic test_img_tx;
        int base;
        int i;
        int k;
        base = tx_log.size();
        stall_viol = 0;
        drdy_viol  = 0;
        tx_toggle  = 1'b1;
        send_byte(8'h08);
        wait_en(10);
        @(posedge clk);
        #1 core_busy = 1'b1;
        i = 0;
        k = 0;
        while (i < 6 && k < 200) begin
            @(negedge clk);
            if (core_dout_ready) begin
                core_dout_valid = 1'b1;
                core_dout       = 8'h40 + 8'(i);
                i++;
            end else begin
                core_dout_valid = 1'b0;
            end
            k++;
        end
        @(negedge clk);
        core_dout_valid = 1'b0;
        core_dout       = 8'h5A;
        wait_tx(base + 6, 100);
        core_busy = 1'b0;
        repeat (10) @(negedge clk);
        tx_toggle = 1'b0;
        tests++;
        if (tx_log.size() != base + 6) begin
            fails++;
            $display("FAIL img_tx_count: ntx=%0d, required %0d (no ack)", tx_log.size(), base + 6);
        end
        for (int j = 0; j < 6; j++) begin
            tests++;
            if (tx_log[base+j] !== 8'h40 + 8'(j)) begin
                fails++;
                $display("FAIL img_tx_byte%0d: tx=%h, required %h", j, tx_log[base+j], 8'h40 + 8'(j));
            end
        end
        tests++;
        if (stall_viol != 0 || drdy_viol != 0) begin
            fails++;
            $display("FAIL img_tx_stall: unstable=%0d ready_while_stalled=%0d, required 0 0", stall_viol, drdy_viol);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base = tx_log.size();
        send_byte(8'h06);
        send_byte(8'h77);
        wait_en(10);
        send_byte(8'h03);
        wait_en(10);
        wait_tx(base + 2, 30);
        tests++;
        if (tx_log[base] !== 8'hA5 || tx_log[base+1] !== 8'h77) begin
            fails++;
            $display("FAIL back_to_back: tx=%h,%h, required a5,77", tx_log[base], tx_log[base+1]);
        end
    endtask

    task automatic test_reset_midstream;
        int base;
        send_byte(8'h07);
        wait_en(10);
        @(posedge clk);
        #1 core_busy = 1'b1;
        send_byte(8'h21);
        send_byte(8'h22);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        tests++;
        if ({rx_ready, tx_valid, tx_data, core_op, core_en, core_din, core_din_valid, core_dout_ready} !== 30'd0) begin
            fails++;
            $display("FAIL midstream_reset: rx_ready=%b tx_valid=%b tx_data=%h op=%h en=%b din=%h, required all 0",
                     rx_ready, tx_valid, tx_data, core_op, core_en, core_din);
        end
        core_busy = 1'b0;
        m_nrows = 8'd8;
        m_ncols = 8'd8;
        m_sigma = 8'h33;
        @(negedge clk);
        rstn = 1'b1;
        base = tx_log.size();
        send_byte(8'h01);
        wait_en(10);
        wait_tx(base + 1, 20);
        tests++;
        if (tx_log[base] !== 8'h08) begin
            fails++;
            $display("FAIL after_reset_get: tx=%h, required 08", tx_log[base]);
        end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout;
        int base;
        int c;
        base = tx_log.size();
        c    = en_cnt;
        send_byte(8'h06);
        repeat (90) @(negedge clk);
        tests++;
        if (tx_log.size() != base) begin
            fails++;
            $display("FAIL timeout_early: ntx=%0d after 90 idle cycles, required %0d", tx_log.size(), base);
        end
        wait_tx(base + 1, 30);
        tests++;
        if (tx_log[base] !== 8'hEE || en_cnt != c) begin
            fails++;
            $display("FAIL timeout_err: tx=%h en_pulses=%0d, required ee en_pulses=%0d", tx_log[base], en_cnt, c);
        end
        send_byte(8'h03);
        wait_en(10);
        wait_tx(base + 2, 20);
        tests++;
        if (tx_log[base+1] !== 8'h33) begin
            fails++;
            $display("FAIL timeout_recover: tx=%h, required 33", tx_log[base+1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_get_default();
        test_set_get();
        test_invalid();
        test_img_rx();
        test_zero_count();
        test_img_tx();
        test_back_to_back();
        test_reset_midstream();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        tests++;
        if (en_busy_viol != 0) begin
            fails++;
            $display("FAIL en_while_busy: count=%0d, required 0", en_busy_viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
